load_unit: RTL and testbench

- Read-side companion to the store path: executes LW/LH/LHU/LB/LBU data-memory reads for the multicycle datapath.
- Sequence per access: issues a word-aligned read to data memory, waits a fixed memory latency, extracts the addressed byte or halfword, and sign- or zero-extends it to 32 bits.
- Misaligned accesses and reserved size codes are reported to the control unit as an exception instead of being performed.
- Sits between the IorD address path / memory output and the register-file write-data mux.

---
 rtl/load_unit.sv | 162 ++++++++++++++++
 tb/tb_load_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: multicycle-datapath data-memory read sequencer.
// Issues a word-aligned read and waits MEM_LATENCY cycles. It then extracts the
// addressed byte/halfword and sign- or zero-extends it. Misaligned accesses and
// reserved size codes raise a one-cycle exception instead of touching memory.
module load_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  load_ctrl,
    input  logic [31:0] addr,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_data,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        exc,
    output logic [1:0]  exc_cause
);

    localparam logic [2:0] LC_LW  = 3'b000;
    localparam logic [2:0] LC_LH  = 3'b001;
    localparam logic [2:0] LC_LHU = 3'b010;
    localparam logic [2:0] LC_LB  = 3'b011;
    localparam logic [2:0] LC_LBU = 3'b100;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RSVD     = 2'b10;

    // Counter value on the last WAIT cycle; mem_data is valid in that cycle.
    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] data_out_q, data_out_d;
    logic [1:0]  exc_cause_q, exc_cause_d;

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;
    logic        req_rsvd;
    logic        req_misalign;

    // Lane selection and extension of the word arriving from memory.
    // The word is consumed on the same edge it is captured, so the extender
    // works straight off mem_data using the latched address and size code.
    always_comb begin
        sel_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: sel_byte = mem_data[7:0];
            2'd1: sel_byte = mem_data[15:8];
            2'd2: sel_byte = mem_data[23:16];
            2'd3: sel_byte = mem_data[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = addr_q[1] ? mem_data[31:16] : mem_data[15:0];
        case (ctrl_q)
            LC_LH:   ext_data = {{16{sel_half[15]}}, sel_half};
            LC_LHU:  ext_data = {16'h0000, sel_half};
            LC_LB:   ext_data = {{24{sel_byte[7]}}, sel_byte};
            LC_LBU:  ext_data = {24'h000000, sel_byte};
            default: ext_data = mem_data;
        endcase
    end

    // Request classification on the live inputs; reserved codes win over alignment.
    always_comb begin
        req_rsvd     = (load_ctrl > LC_LBU);
        req_misalign = 1'b0;
        case (load_ctrl)
            LC_LW:         req_misalign = (addr[1:0] != 2'b00);
            LC_LH, LC_LHU: req_misalign = addr[0];
            default:       req_misalign = 1'b0;
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ctrl_d      = ctrl_q;
        data_out_d  = data_out_q;
        exc_cause_d = exc_cause_q;
        mem_rd      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        exc         = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    addr_d = addr;
                    ctrl_d = load_ctrl;
                    cnt_d  = 4'd0;
                    if (req_rsvd) begin
                        state_d     = S_ERR;
                        exc_cause_d = CAUSE_RSVD;
                    end else if (req_misalign) begin
                        state_d     = S_ERR;
                        exc_cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mem_rd = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = 4'd0;
                    data_out_d = ext_data;
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                exc     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            ctrl_q      <= LC_LW;
            data_out_q  <= 32'h0;
            exc_cause_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ctrl_q      <= ctrl_d;
            data_out_q  <= data_out_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign data_out  = data_out_q;
    assign exc_cause = exc_cause_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: three instances (latency 1, 4, 3) share stimulus.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  load_ctrl = 3'b000;
    logic [31:0] addr = 32'h0;

    logic [31:0] mem_addr1, mem_data1, data_out1;
    logic        mem_rd1, busy1, done1, exc1;
    logic [1:0]  exc_cause1;
    logic [31:0] mem_addr4, mem_data4, data_out4;
    logic        mem_rd4, busy4, done4, exc4;
    logic [1:0]  exc_cause4;
    logic [31:0] mem_addr3, mem_data3, data_out3;
    logic        mem_rd3, busy3, done3, exc3;
    logic [1:0]  exc_cause3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: mem_word = 32'h8899AABB;
            32'h200: mem_word = 32'h12345678;
            default: mem_word = 32'hDEADBEEF;
        endcase
    endfunction

    assign mem_data1 = mem_word(mem_addr1);
    assign mem_data4 = mem_word(mem_addr4);
    assign mem_data3 = mem_word(mem_addr3);

    load_unit #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .load_ctrl(load_ctrl), .addr(addr),
        .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data(mem_data1), .data_out(data_out1),
        .busy(busy1), .done(done1), .exc(exc1), .exc_cause(exc_cause1));

    load_unit #(.MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .load_ctrl(load_ctrl), .addr(addr),
        .mem_addr(mem_addr4), .mem_rd(mem_rd4), .mem_data(mem_data4), .data_out(data_out4),
        .busy(busy4), .done(done4), .exc(exc4), .exc_cause(exc_cause4));

    load_unit #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .load_ctrl(load_ctrl), .addr(addr),
        .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_data(mem_data3), .data_out(data_out3),
        .busy(busy3), .done(done3), .exc(exc3), .exc_cause(exc_cause3));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One access observed on the latency-1 instance. lat = cycles from accept edge.
    task automatic run1(input logic [2:0] c, input logic [31:0] a,
                        output logic [31:0] d, output int lat, output int rd_cnt,
                        output bit got_done, output bit got_exc);
        d = 32'h0; lat = 0; rd_cnt = 0; got_done = 0; got_exc = 0;
        load_ctrl = c; addr = a; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (mem_rd1) rd_cnt++;
            if (done1) begin got_done = 1; d = data_out1; lat = cyc; break; end
            if (exc1)  begin got_exc = 1; lat = cyc; break; end
            tick();
        end
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] exp;
    } vec_t;

    initial begin
        logic [31:0] d;
        int lat, rdc, ndone, done_at, prev;
        bit gd, ge;
        vec_t vecs[5];
        vecs[0] = '{"lw_100",  3'b000, 32'h100, 32'h8899AABB};
        vecs[1] = '{"lb_101",  3'b011, 32'h101, 32'hFFFFFFAA};
        vecs[2] = '{"lbu_103", 3'b100, 32'h103, 32'h00000088};
        vecs[3] = '{"lh_102",  3'b001, 32'h102, 32'hFFFF8899};
        vecs[4] = '{"lhu_100", 3'b010, 32'h100, 32'h0000AABB};

        // Reset state
        #12;
        chk("rst_mem_addr", mem_addr1, 32'h0);
        chk("rst_data_out", data_out1, 32'h0);
        chk("rst_exc_cause", 32'(exc_cause1), 32'h0);
        chk("rst_ctl", {28'h0, mem_rd1, busy1, done1, exc1}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // First load: mem_addr and mem_rd in the single WAIT cycle
        load_ctrl = 3'b000; addr = 32'h100; start = 1'b1;
        tick();
        start = 1'b0;
        chk("lw_wait_mem_rd", 32'(mem_rd1), 32'h1);
        chk("lw_wait_mem_addr", mem_addr1, 32'h100);
        chk("lw_wait_busy", 32'(busy1), 32'h1);
        tick();
        chk("lw_done", 32'(done1), 32'h1);
        chk("lw_done_mem_rd", 32'(mem_rd1), 32'h0);
        chk("lw_data", data_out1, 32'h8899AABB);
        tick();
        chk("lw_idle_busy", 32'(busy1), 32'h0);
        chk("lw_hold_data", data_out1, 32'h8899AABB);
        idle(8);

        // Size/sign variants
        foreach (vecs[i]) begin
            run1(vecs[i].ctrl, vecs[i].a, d, lat, rdc, gd, ge);
            chk({vecs[i].tag, "_done"}, 32'(gd), 32'h1);
            chk({vecs[i].tag, "_lat"}, 32'(lat), 32'd2);
            chk({vecs[i].tag, "_rdcnt"}, 32'(rdc), 32'd1);
            chk({vecs[i].tag, "_data"}, d, vecs[i].exp);
            idle(8);
        end

        // Misaligned LW: exception, no memory read, data_out kept
        run1(3'b000, 32'h102, d, lat, rdc, gd, ge);
        chk("mis_exc", 32'(ge), 32'h1);
        chk("mis_no_done", 32'(gd), 32'h0);
        chk("mis_no_rd", 32'(rdc), 32'd0);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_cause", 32'(exc_cause1), 32'h1);
        chk("mis_keep_data", data_out1, 32'h0000AABB);
        tick();
        chk("mis_exc_pulse", 32'(exc1), 32'h0);
        chk("mis_cause_hold", 32'(exc_cause1), 32'h1);
        idle(8);

        // Reserved code beats misalignment
        run1(3'b111, 32'h101, d, lat, rdc, gd, ge);
        chk("rsvd_exc", 32'(ge), 32'h1);
        chk("rsvd_cause", 32'(exc_cause1), 32'h2);
        chk("rsvd_no_rd", 32'(rdc), 32'd0);
        chk("rsvd_keep_data", data_out1, 32'h0000AABB);
        idle(8);

        // Latency 4 with a second start during WAIT
        load_ctrl = 3'b000; addr = 32'h200; start = 1'b1;
        tick();
        rdc = 0; ndone = 0; done_at = 0; d = 32'h0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            start = (cyc == 2);
            if (cyc == 2) addr = 32'h100;
            if (mem_rd4) rdc++;
            if (done4) begin ndone++; done_at = cyc; d = data_out4; end
            tick();
        end
        start = 1'b0;
        chk("l4_rd_cycles", 32'(rdc), 32'd4);
        chk("l4_done_count", 32'(ndone), 32'd1);
        chk("l4_done_cycle", 32'(done_at), 32'd5);
        chk("l4_data", d, 32'h12345678);
        idle(4);

        // Latency 3, reset in cycle T+2
        load_ctrl = 3'b000; addr = 32'h100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("l3_pre_rst_rd", 32'(mem_rd3), 32'h1);
        reset = 1'b1;
        #1;
        chk("l3_rst_mem_rd", 32'(mem_rd3), 32'h0);
        chk("l3_rst_busy", 32'(busy3), 32'h0);
        chk("l3_rst_data", data_out3, 32'h0);
        chk("l3_rst_cause", 32'(exc_cause3), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (done3) ndone++;
            tick();
        end
        chk("l3_no_done_after_rst", 32'(ndone), 32'd0);
        load_ctrl = 3'b000; addr = 32'h200; start = 1'b1;
        tick();
        start = 1'b0;
        done_at = 0; d = 32'h0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (done3 && done_at == 0) begin done_at = cyc; d = data_out3; end
            tick();
        end
        chk("l3_after_rst_lat", 32'(done_at), 32'd4);
        chk("l3_after_rst_data", d, 32'h12345678);
        idle(4);

        // Back-to-back with start held high: done every 3 cycles on latency 1
        load_ctrl = 3'b011; addr = 32'h100; start = 1'b1;
        tick();
        prev = 0; ndone = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (done1) begin
                ndone++;
                chk("b2b_data", data_out1, 32'hFFFFFFBB);
                if (prev != 0) chk("b2b_period", 32'(cyc - prev), 32'd3);
                prev = cyc;
            end
            tick();
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd5);
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
